// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating dot-product accumulator fed by the 8x8 multiplier.
// Sums `len` unsigned 16-bit products received over a valid/ready handshake and
// presents the result on an output handshake. All outputs are registered.
module mac_accumulator #(
  parameter int ACC_W = 24  // legal range 16..32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  output logic             busy,
  input  logic [15:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic [7:0]       count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [7:0]       r_len;
  logic [7:0]       r_count;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic             r_busy;
  logic             r_prod_ready;
  logic             r_out_valid;

  logic             w_start_ok;
  logic             w_beat;
  logic             w_last;
  logic [ACC_W:0]   w_sum;

  // start is only honoured in IDLE; a beat is only taken while prod_ready is asserted
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_beat     = r_prod_ready && prod_valid;
  // count never reaches 255 while accumulating, so the +1 cannot wrap
  assign w_last     = ((r_count + 8'd1) == r_len);
  // one extra bit catches the carry out that triggers saturation
  assign w_sum      = {1'b0, r_acc} + {{(ACC_W - 15){1'b0}}, prod};

  // next-state decode for the IDLE -> ACCUM/DONE -> IDLE sequence
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (len == 8'd0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_beat && w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // state plus status flags decoded from the next state so they are glitch-free registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_prod_ready <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_prod_ready <= (w_state_next == S_ACCUM);
      r_out_valid  <= (w_state_next == S_DONE);
    end
  end

  // datapath: latch len on start, accumulate with saturation on each accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= 8'd0;
      r_count <= 8'd0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_start_ok) begin
      r_len   <= len;
      r_count <= 8'd0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_beat) begin
      r_count <= r_count + 8'd1;
      if (w_sum[ACC_W]) begin
        // once at all-ones any further sum carries again, so the value sticks
        r_acc <= '1;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign busy       = r_busy;
  assign prod_ready = r_prod_ready;
  assign out_valid  = r_out_valid;
  assign acc_out    = r_acc;
  assign ovf        = r_ovf;
  assign count      = r_count;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: scoreboard bench. Two instances (ACC_W=24 and ACC_W=16)
// share the same stimulus so saturation and full-scale behaviour are both covered.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [15:0] prod = 16'd0;
  logic        prod_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        busy_w, prod_ready_w, out_valid_w, ovf_w;
  logic [23:0] acc_w;
  logic [7:0]  count_w;
  logic        busy_n, prod_ready_n, out_valid_n, ovf_n;
  logic [15:0] acc_n;
  logic [7:0]  count_n;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] acc24;
    logic        ovf24;
    logic [31:0] acc16;
    logic        ovf16;
    logic [7:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(24)) dut_w (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy_w),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready_w),
    .acc_out(acc_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .ovf(ovf_w), .count(count_w)
  );

  mac_accumulator #(.ACC_W(16)) dut_n (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy_n),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready_n),
    .acc_out(acc_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .ovf(ovf_n), .count(count_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, want, want);
  endtask

  task automatic push_exp(input logic [31:0] a24, input logic o24, input logic [31:0] a16,
                          input logic o16, input logic [7:0] c);
    exp_t e;
    e.acc24 = a24; e.ovf24 = o24; e.acc16 = a16; e.ovf16 = o16; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // monitor: compare the first cycle of each out_valid window against the scoreboard
  logic mon_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      mon_seen = 1'b0;
    end else if (out_valid_w && !mon_seen) begin
      mon_seen = 1'b1;
      $display("result acc24=%0d ovf24=%0d acc16=%0d ovf16=%0d count=%0d",
               acc_w, ovf_w, acc_n, ovf_n, count_w);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got acc=%0d expected no result", acc_w);
      end else begin
        e = exp_q.pop_front();
        check("acc24", {8'd0, acc_w}, e.acc24);
        check("ovf24", {31'd0, ovf_w}, {31'd0, e.ovf24});
        check("count24", {24'd0, count_w}, {24'd0, e.cnt});
        check("acc16", {16'd0, acc_n}, e.acc16);
        check("ovf16", {31'd0, ovf_n}, {31'd0, e.ovf16});
        check("valid16", {31'd0, out_valid_n}, 32'd1);
      end
    end else if (!out_valid_w) begin
      mon_seen = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy_w | busy_n}, 32'd0);
    check({tag, "_prod_ready"}, {31'd0, prod_ready_w | prod_ready_n}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid_w | out_valid_n}, 32'd0);
    check({tag, "_ovf"}, {31'd0, ovf_w | ovf_n}, 32'd0);
    check({tag, "_acc"}, {8'd0, acc_w | {8'd0, acc_n}}, 32'd0);
    check({tag, "_count"}, {24'd0, count_w | count_n}, 32'd0);
  endtask

  // called at a negedge; start is taken at the following posedge
  task automatic start_run(input logic [7:0] l);
    start = 1'b1; len = l;
    @(negedge clk);
    start = 1'b0; len = ~l;  // scramble len to show it was latched
    if (l == 8'd0) begin
      check("len0_out_valid_t1", {31'd0, out_valid_w}, 32'd1);
      check("len0_prod_ready", {31'd0, prod_ready_w}, 32'd0);
    end else begin
      check("busy_t1", {31'd0, busy_w}, 32'd1);
      check("prod_ready_t1", {31'd0, prod_ready_w}, 32'd1);
    end
  endtask

  task automatic send(input logic [15:0] p);
    check("prod_ready_beat", {31'd0, prod_ready_w}, 32'd1);
    prod = p; prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int i;
    for (i = 0; i < max_cycles && !out_valid_w; i++) @(negedge clk);
    if (!out_valid_w) begin
      n_checks++;
      $display("FAIL wait_valid: out_valid still 0 after %0d cycles, expected 1", max_cycles);
    end
  endtask

  // hold out_ready low for `hold` cycles checking the result is stable, then handshake
  task automatic finish_run(input int hold, input logic [31:0] want_acc);
    for (int i = 0; i < hold; i++) begin
      check("hold_out_valid", {31'd0, out_valid_w}, 32'd1);
      check("hold_acc", {8'd0, acc_w}, want_acc);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_valid", {31'd0, out_valid_w}, 32'd0);
    check("idle_busy", {31'd0, busy_w}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // basic run: 10+20+30, out_valid exactly 4 cycles after start
    push_exp(60, 0, 60, 0, 3);
    start_run(8'd3);
    send(16'd10);
    send(16'd20);
    check("basic_out_valid_early", {31'd0, out_valid_w}, 32'd0);
    send(16'd30);
    check("basic_out_valid_t4", {31'd0, out_valid_w}, 32'd1);
    check("acc_kept_in_done", {8'd0, acc_w}, 32'd60);
    finish_run(0, 32'd60);
    check("acc_kept_in_idle", {8'd0, acc_w}, 32'd60);

    // saturation: 0xFE01 + 0xFE01 = 0x1FC02 overflows 16 bits
    push_exp(32'h1FC02, 0, 32'hFFFF, 1, 2);
    start_run(8'd2);
    send(16'hFE01);
    send(16'hFE01);
    wait_valid(4);
    finish_run(0, 32'h1FC02);
    check("ovf16_sticky_idle", {31'd0, ovf_n}, 32'd1);
    push_exp(5, 0, 5, 0, 1);
    start_run(8'd1);
    check("ovf16_cleared", {31'd0, ovf_n}, 32'd0);
    check("acc16_cleared", {16'd0, acc_n}, 32'd0);
    send(16'd5);
    wait_valid(4);
    finish_run(0, 32'd5);

    // zero length with prod_valid high: nothing accepted
    push_exp(0, 0, 0, 0, 0);
    prod = 16'h1234; prod_valid = 1'b1;
    start_run(8'd0);
    // start during the DONE handshake cycle is ignored
    out_ready = 1'b1; start = 1'b1; len = 8'd2;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0; prod_valid = 1'b0;
    check("hs_start_ignored_busy", {31'd0, busy_w}, 32'd0);
    @(negedge clk);
    check("hs_start_not_latched", {31'd0, busy_w}, 32'd0);

    // start pulse during ACCUM is ignored (len 3 stays latched)
    push_exp(6, 0, 6, 0, 3);
    start_run(8'd3);
    send(16'd1);
    start = 1'b1; len = 8'd7;
    @(negedge clk);
    start = 1'b0;
    check("accum_start_count", {24'd0, count_w}, 32'd1);
    check("accum_start_acc", {8'd0, acc_w}, 32'd1);
    send(16'd2);
    send(16'd3);
    check("accum_start_done", {31'd0, out_valid_w}, 32'd1);
    finish_run(0, 32'd6);

    // backpressure: alternate-cycle valid, out_ready low for 5 cycles
    push_exp(1000, 0, 1000, 0, 4);
    start_run(8'd4);
    send(16'd100); @(negedge clk);
    send(16'd200); @(negedge clk);
    send(16'd300); @(negedge clk);
    check("bp_count_stall", {24'd0, count_w}, 32'd3);
    send(16'd400);
    wait_valid(4);
    finish_run(5, 32'd1000);

    // reset mid-run discards the partial sum
    start_run(8'd5);
    send(16'd7);
    send(16'd9);
    check("mid_partial", {8'd0, acc_w}, 32'd16);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_exp(5, 0, 5, 0, 1);
    start_run(8'd1);
    send(16'd5);
    wait_valid(4);
    finish_run(0, 32'd5);

    // full scale: 255 x 65025 = 16581375, saturates the 16-bit instance
    push_exp(32'd16581375, 0, 32'hFFFF, 1, 255);
    start_run(8'd255);
    for (int i = 0; i < 255; i++) send(16'hFE01);
    wait_valid(4);
    finish_run(0, 32'd16581375);

    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
